l1a_align_monitor: RTL and testbench

Downstream consumer of the 16-ADC L1A cross-checker. Turns the checker's per-ADC progress pulses, alignment pulse and error vector into per-event verdicts, and checks that event L1A numbers increment by 1 (mod 2^L1A_W) between events. Detects an event that stalls because an ADC never reports. Keeps saturating statistics and sticky diagnostics for slow control. Raises a resync request after repeated consecutive failures.

---
 rtl/l1a_align_monitor_pkg.sv | 30 +++
 rtl/l1a_align_monitor_if.sv | 28 ++
 rtl/l1a_align_monitor_sat_counter.sv | 34 +++
 rtl/l1a_align_monitor.sv | 198 +++++++++++++++++++
 tb/tb_l1a_align_monitor.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/l1a_align_monitor_pkg.sv
// rtl/l1a_align_monitor_pkg.sv - shared constants, FSM state and verdict types for the L1A alignment monitor
package l1a_pkg;

  localparam int N_ADC_DEF = 16;
  localparam int L1A_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    RESYNC
  } state_e;

  typedef enum logic [1:0] {
    VERDICT_GOOD,
    VERDICT_BAD,
    VERDICT_TIMEOUT
  } verdict_e;

  // Lowest set bit index; callers only use the result when v is non-zero.
  function automatic logic [3:0] first_set_idx(input logic [N_ADC_DEF-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = N_ADC_DEF - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/l1a_align_monitor_if.sv
// rtl/l1a_align_monitor_if.sv - checker-to-monitor pulse/flag bundle
interface l1a_align_monitor_if
  import l1a_pkg::*;
#(
  parameter int N_ADC = N_ADC_DEF,
  parameter int L1A_W = L1A_W_DEF
);

  logic             one_adc_finish_check;
  logic             l1a_align;
  logic [N_ADC-1:0] error;
  logic [L1A_W-1:0] l1a_ref;

  modport master (
    output one_adc_finish_check,
    output l1a_align,
    output error,
    output l1a_ref
  );

  modport slave (
    input one_adc_finish_check,
    input l1a_align,
    input error,
    input l1a_ref
  );

endinterface

// File: rtl/l1a_align_monitor_sat_counter.sv
// rtl/l1a_align_monitor_sat_counter.sv - saturating event counter; clear beats increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/l1a_align_monitor.sv
// rtl/l1a_align_monitor.sv - per-event L1A alignment verdicts, sequence check, stall detection and resync request
module l1a_align_monitor
  import l1a_pkg::*;
#(
  parameter int N_ADC         = N_ADC_DEF,
  parameter int L1A_W         = L1A_W_DEF,
  parameter int CNT_W         = 16,
  parameter int TIMEOUT       = 65535,
  parameter int TMR_W         = 16,
  parameter int RESYNC_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  l1a_align_monitor_if.slave   chk,
  input  logic                 clear_counters,
  input  logic                 resync_ack,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     bad_cnt,
  output logic [CNT_W-1:0]     timeout_cnt,
  output logic [CNT_W-1:0]     seq_err_cnt,
  output logic [N_ADC-1:0]     err_sticky,
  output logic [3:0]           first_bad_adc,
  output logic                 first_bad_valid,
  output logic [3:0]           stall_adc,
  output logic [L1A_W-1:0]     last_l1a,
  output logic [4:0]           progress,
  output logic                 busy,
  output logic                 resync_req
);

  localparam int CF_W = $clog2(RESYNC_THRESH + 1);

  state_e           state_q;
  verdict_e         verdict_q;
  logic [L1A_W-1:0] l1a_cap_q;
  logic [L1A_W-1:0] last_l1a_q;
  logic [TMR_W-1:0] timer_q;
  logic [CF_W-1:0]  consec_fail_q;
  logic             seq_valid_q;
  logic [4:0]       progress_q;
  logic [3:0]       stall_adc_q;
  logic             busy_q;
  logic             resync_req_q;
  logic [N_ADC-1:0] err_sticky_q;
  logic [3:0]       first_bad_adc_q;
  logic             first_bad_valid_q;

  logic             finish;
  logic [4:0]       progress_d;
  logic [TMR_W-1:0] timer_d;
  logic [CF_W-1:0]  consec_fail_d;
  logic [L1A_W-1:0] exp_l1a;
  logic             eval_fire;
  logic             inc_good, inc_bad, inc_tmo, inc_seq;

  assign finish        = chk.one_adc_finish_check;
  assign progress_d    = progress_q + 5'd1;
  assign timer_d       = timer_q + TMR_W'(1);
  assign consec_fail_d = consec_fail_q + CF_W'(1);
  assign exp_l1a       = last_l1a_q + L1A_W'(1);

  // Statistics are committed on the edge that leaves EVAL, unless enable drops and aborts it.
  assign eval_fire = (state_q == EVAL) && enable;
  assign inc_good  = eval_fire && (verdict_q == VERDICT_GOOD);
  assign inc_bad   = eval_fire && (verdict_q == VERDICT_BAD);
  assign inc_tmo   = eval_fire && (verdict_q == VERDICT_TIMEOUT);
  assign inc_seq   = eval_fire && (verdict_q != VERDICT_TIMEOUT) && seq_valid_q
                     && (l1a_cap_q != exp_l1a);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      verdict_q     <= VERDICT_GOOD;
      l1a_cap_q     <= '0;
      last_l1a_q    <= '0;
      timer_q       <= '0;
      consec_fail_q <= '0;
      seq_valid_q   <= 1'b0;
      progress_q    <= '0;
      stall_adc_q   <= '0;
      busy_q        <= 1'b0;
      resync_req_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && finish) begin
            l1a_cap_q  <= chk.l1a_ref;
            progress_q <= 5'd1;
            timer_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= COLLECT;
          end
        end
        COLLECT: begin
          if (!enable) begin
            progress_q <= '0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (finish) begin
            progress_q <= progress_d;
            timer_q    <= '0;
            if (progress_d == 5'(N_ADC)) begin
              verdict_q <= chk.l1a_align ? VERDICT_GOOD : VERDICT_BAD;
              state_q   <= EVAL;
            end
          end else begin
            timer_q <= timer_d;
            if (timer_d == TMR_W'(TIMEOUT)) begin
              verdict_q   <= VERDICT_TIMEOUT;
              stall_adc_q <= progress_q[3:0];
              state_q     <= EVAL;
            end
          end
        end
        EVAL: begin
          progress_q <= '0;
          if (!enable) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (verdict_q == VERDICT_TIMEOUT) begin
              seq_valid_q <= 1'b0;
            end else begin
              last_l1a_q  <= l1a_cap_q;
              seq_valid_q <= 1'b1;
            end
            if (verdict_q == VERDICT_GOOD) begin
              consec_fail_q <= '0;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end else if (consec_fail_d >= CF_W'(RESYNC_THRESH)) begin
              consec_fail_q <= consec_fail_d;
              resync_req_q  <= 1'b1;
              state_q       <= RESYNC;
            end else begin
              consec_fail_q <= consec_fail_d;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end
          end
        end
        RESYNC: begin
          if (resync_ack) begin
            resync_req_q  <= 1'b0;
            consec_fail_q <= '0;
            seq_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q      <= '0;
      first_bad_adc_q   <= '0;
      first_bad_valid_q <= 1'b0;
    end else if (clear_counters) begin
      err_sticky_q      <= '0;
      first_bad_valid_q <= 1'b0;
    end else if (enable) begin
      err_sticky_q <= err_sticky_q | chk.error;
      if (!first_bad_valid_q && (|chk.error)) begin
        first_bad_adc_q   <= first_set_idx(chk.error);
        first_bad_valid_q <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
    .clk(clk), .reset(reset), .inc_i(inc_good), .clr_i(clear_counters), .cnt_o(good_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
    .clk(clk), .reset(reset), .inc_i(inc_bad), .clr_i(clear_counters), .cnt_o(bad_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk(clk), .reset(reset), .inc_i(inc_tmo), .clr_i(clear_counters), .cnt_o(timeout_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_seq_err_cnt (
    .clk(clk), .reset(reset), .inc_i(inc_seq), .clr_i(clear_counters), .cnt_o(seq_err_cnt)
  );

  assign err_sticky      = err_sticky_q;
  assign first_bad_adc   = first_bad_adc_q;
  assign first_bad_valid = first_bad_valid_q;
  assign stall_adc       = stall_adc_q;
  assign last_l1a        = last_l1a_q;
  assign progress        = progress_q;
  assign busy            = busy_q;
  assign resync_req      = resync_req_q;

endmodule

// File: tb/tb_l1a_align_monitor.sv
// tb/tb_l1a_align_monitor.sv - directed self-checking bench for l1a_align_monitor
module tb_l1a_align_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear_counters;
  logic        resync_ack;
  logic [15:0] good_cnt, bad_cnt, timeout_cnt, seq_err_cnt;
  logic [15:0] err_sticky;
  logic [3:0]  first_bad_adc;
  logic        first_bad_valid;
  logic [3:0]  stall_adc;
  logic [13:0] last_l1a;
  logic [4:0]  progress;
  logic        busy;
  logic        resync_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1a_align_monitor_if #(.N_ADC(16), .L1A_W(14)) chk_if ();

  l1a_align_monitor #(
    .N_ADC(16), .L1A_W(14), .CNT_W(16), .TIMEOUT(100), .TMR_W(16), .RESYNC_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .chk(chk_if.slave),
    .clear_counters(clear_counters), .resync_ack(resync_ack),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt), .timeout_cnt(timeout_cnt),
    .seq_err_cnt(seq_err_cnt), .err_sticky(err_sticky), .first_bad_adc(first_bad_adc),
    .first_bad_valid(first_bad_valid), .stall_adc(stall_adc), .last_l1a(last_l1a),
    .progress(progress), .busy(busy), .resync_req(resync_req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic align);
    chk_if.one_adc_finish_check = 1'b1;
    chk_if.l1a_align = align;
    tick();
    chk_if.one_adc_finish_check = 1'b0;
    chk_if.l1a_align = 1'b0;
  endtask

  // n pulses three cycles apart; at pulse err_at an early l1a_align is sent and err_val is driven for two cycles.
  task automatic run_event(input logic [13:0] l1a, input int n, input logic align_last,
                           input int err_at, input logic [15:0] err_val);
    chk_if.l1a_ref = l1a;
    for (int i = 0; i < n; i++) begin
      pulse((i == n - 1) ? align_last : (i == err_at));
      if (i != n - 1) begin
        if (i == err_at) chk_if.error = err_val;
        tick();
        tick();
        chk_if.error = '0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    clear_counters = 1'b0;
    resync_ack = 1'b0;
    chk_if.one_adc_finish_check = 1'b0;
    chk_if.l1a_align = 1'b0;
    chk_if.error = '0;
    chk_if.l1a_ref = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_good", 32'(good_cnt), 0);
    check("rst_bad", 32'(bad_cnt), 0);
    check("rst_tmo", 32'(timeout_cnt), 0);
    check("rst_seq", 32'(seq_err_cnt), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_fbv", 32'(first_bad_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(resync_req), 0);
    check("rst_prog", 32'(progress), 0);

    run_event(14'h0005, 16, 1'b1, -1, 16'h0);
    check("ev1_eval_prog", 32'(progress), 16);
    check("ev1_eval_busy", 32'(busy), 1);
    check("ev1_eval_good", 32'(good_cnt), 0);
    tick();
    check("ev1_good", 32'(good_cnt), 1);
    check("ev1_last", 32'(last_l1a), 32'h5);
    check("ev1_prog", 32'(progress), 0);
    check("ev1_busy", 32'(busy), 0);
    check("ev1_req", 32'(resync_req), 0);
    check("ev1_seq", 32'(seq_err_cnt), 0);

    run_event(14'h0007, 16, 1'b1, -1, 16'h0);
    tick();
    check("ev2_seq", 32'(seq_err_cnt), 1);
    check("ev2_last", 32'(last_l1a), 32'h7);

    run_event(14'h3FFF, 16, 1'b1, -1, 16'h0);
    tick();
    check("ev3_seq", 32'(seq_err_cnt), 2);
    run_event(14'h0000, 16, 1'b1, -1, 16'h0);
    tick();
    check("wrap_seq", 32'(seq_err_cnt), 2);
    check("wrap_good", 32'(good_cnt), 4);
    check("wrap_last", 32'(last_l1a), 0);

    run_event(14'h0001, 16, 1'b0, 8, 16'h0008);
    tick();
    check("bad_cnt", 32'(bad_cnt), 1);
    check("bad_good", 32'(good_cnt), 4);
    check("bad_sticky", 32'(err_sticky), 32'h0008);
    check("bad_fba", 32'(first_bad_adc), 3);
    check("bad_fbv", 32'(first_bad_valid), 1);
    check("bad_seq", 32'(seq_err_cnt), 2);
    chk_if.error = 16'h0030;
    tick();
    chk_if.error = '0;
    check("sticky_or", 32'(err_sticky), 32'h0038);
    check("fba_hold", 32'(first_bad_adc), 3);

    run_event(14'h0002, 5, 1'b0, -1, 16'h0);
    for (int i = 0; i < 99; i++) tick();
    check("tmo_pre_busy", 32'(busy), 1);
    check("tmo_pre_prog", 32'(progress), 5);
    tick();
    check("tmo_eval_cnt", 32'(timeout_cnt), 0);
    check("tmo_eval_stall", 32'(stall_adc), 5);
    tick();
    check("tmo_cnt", 32'(timeout_cnt), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_last", 32'(last_l1a), 32'h1);

    run_event(14'h0100, 16, 1'b1, -1, 16'h0);
    tick();
    check("post_tmo_seq", 32'(seq_err_cnt), 2);
    check("post_tmo_good", 32'(good_cnt), 5);

    run_event(14'h0101, 16, 1'b1, -1, 16'h0);
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    check("clr_good", 32'(good_cnt), 0);
    check("clr_bad", 32'(bad_cnt), 0);
    check("clr_tmo", 32'(timeout_cnt), 0);
    check("clr_seq", 32'(seq_err_cnt), 0);
    check("clr_sticky", 32'(err_sticky), 0);
    check("clr_fbv", 32'(first_bad_valid), 0);
    check("clr_last", 32'(last_l1a), 32'h101);
    check("clr_stall", 32'(stall_adc), 5);

    for (int k = 0; k < 4; k++) begin
      run_event(14'(32'h102 + k), 16, 1'b0, -1, 16'h0);
      tick();
      if (k < 3) check("pre_resync_req", 32'(resync_req), 0);
    end
    check("rs_req", 32'(resync_req), 1);
    check("rs_busy", 32'(busy), 1);
    check("rs_bad", 32'(bad_cnt), 4);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) pulse(1'b0);
      else tick();
    end
    check("rs_hold_req", 32'(resync_req), 1);
    check("rs_ignore_prog", 32'(progress), 0);
    resync_ack = 1'b1;
    tick();
    resync_ack = 1'b0;
    check("rs_drop_req", 32'(resync_req), 0);
    check("rs_idle", 32'(busy), 0);

    run_event(14'h0200, 16, 1'b1, -1, 16'h0);
    tick();
    check("post_rs_good", 32'(good_cnt), 1);
    check("post_rs_seq", 32'(seq_err_cnt), 0);

    run_event(14'h0300, 8, 1'b0, -1, 16'h0);
    check("mid_prog", 32'(progress), 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_good", 32'(good_cnt), 0);
    check("mr_bad", 32'(bad_cnt), 0);
    check("mr_last", 32'(last_l1a), 0);
    check("mr_stall", 32'(stall_adc), 0);
    check("mr_prog", 32'(progress), 0);
    check("mr_busy", 32'(busy), 0);
    run_event(14'h0010, 16, 1'b1, -1, 16'h0);
    tick();
    check("mr_next_good", 32'(good_cnt), 1);
    check("mr_next_last", 32'(last_l1a), 32'h10);
    check("mr_next_seq", 32'(seq_err_cnt), 0);

    run_event(14'h0011, 8, 1'b0, -1, 16'h0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("abort_busy", 32'(busy), 0);
    check("abort_prog", 32'(progress), 0);
    check("abort_good", 32'(good_cnt), 1);
    run_event(14'h0012, 16, 1'b1, -1, 16'h0);
    tick();
    check("abort_seq", 32'(seq_err_cnt), 1);
    check("abort_last", 32'(last_l1a), 32'h12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
